// File: rtl/bus_seq_pkg.sv
// Shared definitions for the bus sequencer: op encodings and T-state roles.
package bus_seq_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_FETCH = 2'b01,
    OP_WRITE = 2'b10,
    OP_READ  = 2'b11
  } bus_op_e;

  localparam int T_SETUP = 0;
  localparam int NCH_MAX = 4;

  // Sample and idle T-states sit at the tail of every M-cycle.
  function automatic int t_sample(input int tcyc);
    return tcyc - 2;
  endfunction

  function automatic int t_idle(input int tcyc);
    return tcyc - 1;
  endfunction

endpackage

// File: rtl/bus_arb.sv
// Fixed-priority NCH-way arbiter: lowest eligible index wins.
module bus_arb
  import bus_seq_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic [NCH-1:0] elig,
  output logic [NCH-1:0] gnt,
  output logic [1:0]     gnt_idx,
  output logic           any
);

  logic [NCH:0] taken;

  assign taken[0] = 1'b0;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_pri
    assign gnt[gi]     = elig[gi] & ~taken[gi];
    assign taken[gi+1] = taken[gi] | elig[gi];
  end

  assign any = taken[NCH];

  always_comb begin
    gnt_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) gnt_idx = 2'(i);
    end
  end

endmodule

// File: rtl/bus_seq.sv
// Multi-channel bus sequencer: one granted transfer per M-cycle of TCYC T-states.
module bus_seq
  import bus_seq_pkg::*;
#(
  parameter int AW   = 16,
  parameter int DW   = 8,
  parameter int TCYC = 4,
  parameter int NCH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  input  logic [2*NCH-1:0]  req_op,
  input  logic [AW*NCH-1:0] req_addr,
  input  logic [DW*NCH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [1:0]        rsp_ch,
  output logic [DW-1:0]     rsp_data,
  output logic [AW-1:0]     a,
  output logic [DW-1:0]     dout,
  input  logic [DW-1:0]     din,
  output logic              rd,
  output logic              wr,
  output logic              phi,
  input  logic              wait_n,
  output logic              mcycle_end
);

  localparam int TW = $clog2(TCYC);
  localparam logic [TW-1:0] T0_C = TW'(T_SETUP);
  localparam logic [TW-1:0] TS_C = TW'(t_sample(TCYC));
  localparam logic [TW-1:0] TL_C = TW'(t_idle(TCYC));

  logic [NCH-1:0] elig;
  logic [NCH-1:0] gnt;
  logic [1:0]     gnt_idx;
  logic           gnt_any;

  // Padded to NCH_MAX so the 2-bit grant index always selects in range.
  logic [AW-1:0] ch_addr  [NCH_MAX];
  logic [DW-1:0] ch_wdata [NCH_MAX];
  bus_op_e       ch_op    [NCH_MAX];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_elig
    assign elig[gi] = req_valid[gi] && (req_op[2*gi +: 2] != OP_NONE);
  end

  for (genvar gi = 0; gi < NCH_MAX; gi++) begin : g_unpack
    if (gi < NCH) begin : g_live
      assign ch_addr[gi]  = req_addr[AW*gi +: AW];
      assign ch_wdata[gi] = req_wdata[DW*gi +: DW];
      assign ch_op[gi]    = bus_op_e'(req_op[2*gi +: 2]);
    end else begin : g_pad
      assign ch_addr[gi]  = '0;
      assign ch_wdata[gi] = '0;
      assign ch_op[gi]    = OP_NONE;
    end
  end

  bus_arb #(.NCH(NCH)) u_arb (
    .elig    (elig),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  logic [TW-1:0] tcnt_reg;
  logic          busy_reg;
  bus_op_e       op_reg;
  logic [1:0]    ch_reg;
  logic [DW-1:0] wdata_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_reg   <= T0_C;
      busy_reg   <= 1'b0;
      op_reg     <= OP_NONE;
      ch_reg     <= '0;
      wdata_reg  <= '0;
      req_ready  <= '0;
      rsp_valid  <= 1'b0;
      rsp_ch     <= '0;
      rsp_data   <= '0;
      a          <= '0;
      dout       <= '0;
      rd         <= 1'b0;
      wr         <= 1'b0;
      phi        <= 1'b0;
      mcycle_end <= 1'b0;
    end else begin
      req_ready  <= '0;
      rsp_valid  <= 1'b0;
      mcycle_end <= 1'b0;
      if (tcnt_reg == T0_C) begin
        tcnt_reg <= tcnt_reg + TW'(1);
        busy_reg <= gnt_any;
        rd       <= 1'b0;
        wr       <= 1'b0;
        if (gnt_any) begin
          req_ready <= gnt;
          a         <= ch_addr[gnt_idx];
          wdata_reg <= ch_wdata[gnt_idx];
          op_reg    <= ch_op[gnt_idx];
          ch_reg    <= gnt_idx;
          phi       <= 1'b1;
          rd        <= (ch_op[gnt_idx] != OP_WRITE);
        end
      end else if (tcnt_reg == TS_C) begin
        // wait_n low freezes everything, including the counter.
        if (wait_n) begin
          tcnt_reg   <= TL_C;
          rd         <= 1'b0;
          phi        <= 1'b0;
          mcycle_end <= 1'b1;
          if (busy_reg) begin
            if (op_reg == OP_WRITE) begin
              wr   <= 1'b1;
              dout <= wdata_reg;
            end else begin
              rsp_data  <= din;
              rsp_valid <= 1'b1;
              rsp_ch    <= ch_reg;
            end
          end
        end
      end else if (tcnt_reg == TL_C) begin
        tcnt_reg <= T0_C;
        busy_reg <= 1'b0;
        rd       <= 1'b0;
        wr       <= 1'b0;
        dout     <= '0;
      end else begin
        tcnt_reg <= tcnt_reg + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_seq.sv
// Directed bench for bus_seq: a TCYC=4/NCH=2 instance and a TCYC=6/NCH=4 instance.
module tb_bus_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (TCYC=4, NCH=2)
  logic        rst;
  logic [1:0]  a_req_valid, a_req_ready;
  logic [3:0]  a_req_op;
  logic [31:0] a_req_addr;
  logic [15:0] a_req_wdata;
  logic        a_rsp_valid, a_rd, a_wr, a_phi, a_wait_n, a_mcycle_end;
  logic [1:0]  a_rsp_ch;
  logic [7:0]  a_rsp_data, a_dout, a_din;
  logic [15:0] a_a;

  // Instance B: TCYC=6, NCH=4
  logic        rst_b;
  logic [3:0]  b_req_valid, b_req_ready;
  logic [7:0]  b_req_op;
  logic [63:0] b_req_addr;
  logic [31:0] b_req_wdata;
  logic        b_rsp_valid, b_rd, b_wr, b_phi, b_wait_n, b_mcycle_end;
  logic [1:0]  b_rsp_ch;
  logic [7:0]  b_rsp_data, b_dout, b_din;
  logic [15:0] b_a;

  bus_seq u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ch(a_rsp_ch), .rsp_data(a_rsp_data),
    .a(a_a), .dout(a_dout), .din(a_din),
    .rd(a_rd), .wr(a_wr), .phi(a_phi), .wait_n(a_wait_n), .mcycle_end(a_mcycle_end)
  );

  bus_seq #(.AW(16), .DW(8), .TCYC(6), .NCH(4)) u_b (
    .clk(clk), .rst(rst_b),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ch(b_rsp_ch), .rsp_data(b_rsp_data),
    .a(b_a), .dout(b_dout), .din(b_din),
    .rd(b_rd), .wr(b_wr), .phi(b_phi), .wait_n(b_wait_n), .mcycle_end(b_mcycle_end)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; rst_b = 1'b0;
    a_req_valid = '0; a_req_op = '0; a_req_addr = '0; a_req_wdata = '0;
    a_din = '0; a_wait_n = 1'b1;
    b_req_valid = '0; b_req_op = '0; b_req_addr = '0; b_req_wdata = '0;
    b_din = '0; b_wait_n = 1'b1;
    step(); step();

    // Reset state
    check("rst_a",        32'(a_a), 32'h0);
    check("rst_rd_wr_phi", {29'b0, a_rd, a_wr, a_phi}, 32'h0);
    check("rst_ready",    32'(a_req_ready), 32'h0);
    check("rst_rsp",      {23'b0, a_rsp_valid, a_rsp_data}, 32'h0);
    check("rst_mend",     32'(a_mcycle_end), 32'h0);
    $display("txn reset state checked");

    // ch0 read 0x1234, din=0xA5; released into T0 with the request pending
    a_req_valid[0] = 1'b1; a_req_op[1:0] = 2'b11; a_req_addr[15:0] = 16'h1234;
    a_din = 8'hA5; rst = 1'b1;
    step();                                         // T1
    check("rd0_ready", 32'(a_req_ready), 32'h1);
    check("rd0_addr",  32'(a_a), 32'h1234);
    check("rd0_rd_t1", 32'(a_rd), 32'h1);
    check("rd0_phi",   32'(a_phi), 32'h1);
    a_req_valid[0] = 1'b0; a_req_addr[15:0] = 16'hDEAD;
    step();                                         // T2 (sample)
    check("rd0_rd_t2",   32'(a_rd), 32'h1);
    check("rd0_ready_1", 32'(a_req_ready), 32'h0);
    check("rd0_rsp_early", 32'(a_rsp_valid), 32'h0);
    step();                                         // T3 (idle)
    check("rd0_rd_t3",   32'(a_rd), 32'h0);
    check("rd0_rsp_v",   32'(a_rsp_valid), 32'h1);
    check("rd0_rsp_d",   32'(a_rsp_data), 32'hA5);
    check("rd0_rsp_ch",  32'(a_rsp_ch), 32'h0);
    check("rd0_mend",    32'(a_mcycle_end), 32'h1);
    check("rd0_addr_hold", 32'(a_a), 32'h1234);
    step();                                         // T0
    check("rd0_rsp_pulse", 32'(a_rsp_valid), 32'h0);
    check("rd0_mend_pulse", 32'(a_mcycle_end), 32'h0);
    $display("txn ch0 read 0x1234 data 0xa5");

    // ch0 and ch1 both request in the same T0
    a_req_valid = 2'b11; a_req_op = 4'b1111;
    a_req_addr = {16'h0200, 16'h0100}; a_din = 8'h11;
    step();
    check("pri_ready0", 32'(a_req_ready), 32'h1);
    check("pri_addr0",  32'(a_a), 32'h0100);
    a_req_valid[0] = 1'b0;
    step(); step();
    check("pri_rsp0_v",  32'(a_rsp_valid), 32'h1);
    check("pri_rsp0_ch", 32'(a_rsp_ch), 32'h0);
    check("pri_rsp0_d",  32'(a_rsp_data), 32'h11);
    a_din = 8'h22;
    step(); step();
    check("pri_ready1", 32'(a_req_ready), 32'h2);
    check("pri_addr1",  32'(a_a), 32'h0200);
    a_req_valid[1] = 1'b0;
    step(); step();
    check("pri_rsp1_v",  32'(a_rsp_valid), 32'h1);
    check("pri_rsp1_ch", 32'(a_rsp_ch), 32'h1);
    check("pri_rsp1_d",  32'(a_rsp_data), 32'h22);
    step();
    $display("txn ch0/ch1 contention resolved in priority order");

    // ch1 write 0xFF40 data 0x3C with three wait states at TS
    a_req_valid[1] = 1'b1; a_req_op[3:2] = 2'b10;
    a_req_addr[31:16] = 16'hFF40; a_req_wdata[15:8] = 8'h3C;
    step();                                         // T1
    check("wr_ready", 32'(a_req_ready), 32'h2);
    check("wr_addr",  32'(a_a), 32'hFF40);
    check("wr_rd",    32'(a_rd), 32'h0);
    a_req_valid[1] = 1'b0; a_req_addr[31:16] = 16'h0BAD; a_req_wdata[15:8] = 8'hEE;
    a_wait_n = 1'b0;
    step();                                         // T2 (sample), first clock
    for (int i = 0; i < 3; i++) begin
      step();                                       // held in sample
      check("wr_hold_wr",   32'(a_wr), 32'h0);
      check("wr_hold_mend", 32'(a_mcycle_end), 32'h0);
      check("wr_hold_phi",  32'(a_phi), 32'h1);
    end
    a_wait_n = 1'b1;
    step();                                         // T3
    check("wr_wr",     32'(a_wr), 32'h1);
    check("wr_dout",   32'(a_dout), 32'h3C);
    check("wr_norsp",  32'(a_rsp_valid), 32'h0);
    check("wr_mend",   32'(a_mcycle_end), 32'h1);
    check("wr_addr_t3", 32'(a_a), 32'hFF40);
    step();                                         // T0
    check("wr_wr_off",   32'(a_wr), 32'h0);
    check("wr_dout_off", 32'(a_dout), 32'h0);
    $display("txn ch1 write 0xff40 data 0x3c with 3 wait states");

    // Three idle M-cycles
    for (int i = 1; i <= 12; i++) begin
      step();
      check("idle_mend",  32'(a_mcycle_end), (i % 4 == 3) ? 32'h1 : 32'h0);
      check("idle_rd_wr", {30'b0, a_rd, a_wr}, 32'h0);
      check("idle_rsp",   32'(a_rsp_valid), 32'h0);
    end
    $display("txn three idle M-cycles");

    // Reset asserted in T1 of a read
    a_req_valid[0] = 1'b1; a_req_op[1:0] = 2'b11; a_req_addr[15:0] = 16'h4321; a_din = 8'h77;
    step();                                         // T1
    check("arst_rd_before", 32'(a_rd), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("arst_a",     32'(a_a), 32'h0);
    check("arst_rd",    {30'b0, a_rd, a_phi}, 32'h0);
    check("arst_ready", 32'(a_req_ready), 32'h0);
    step();
    check("arst_rsp1", 32'(a_rsp_valid), 32'h0);
    step();
    check("arst_rsp2", 32'(a_rsp_valid), 32'h0);
    rst = 1'b1;                                     // next edge is a T0
    step();
    check("arst_regrant", 32'(a_req_ready), 32'h1);
    check("arst_addr",    32'(a_a), 32'h4321);
    a_req_valid[0] = 1'b0;
    step();
    check("arst_rsp_t2", 32'(a_rsp_valid), 32'h0);
    step();
    check("arst_rsp_v", 32'(a_rsp_valid), 32'h1);
    check("arst_rsp_d", 32'(a_rsp_data), 32'h77);
    step();
    $display("txn read aborted by reset then regranted");

    // Instance B: ch3 fetch, ch1 valid with op none must be ignored
    b_req_valid = 4'b1010; b_req_op = 8'b01_00_00_00;
    b_req_addr[63:48] = 16'hBEEF; b_din = 8'h5A; rst_b = 1'b1;
    step();
    check("b_ready", 32'(b_req_ready), 32'h8);
    check("b_addr",  32'(b_a), 32'hBEEF);
    check("b_rd",    32'(b_rd), 32'h1);
    b_req_valid = '0;
    for (int i = 2; i <= 4; i++) begin
      step();
      check("b_rsp_early", 32'(b_rsp_valid), 32'h0);
    end
    step();                                         // 5 clocks after grant
    check("b_rsp_v",  32'(b_rsp_valid), 32'h1);
    check("b_rsp_ch", 32'(b_rsp_ch), 32'h3);
    check("b_rsp_d",  32'(b_rsp_data), 32'h5A);
    check("b_mend",   32'(b_mcycle_end), 32'h1);
    step();
    check("b_rsp_off", 32'(b_rsp_valid), 32'h0);
    $display("txn tcyc6 ch3 fetch 0xbeef data 0x5a");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_seq.md
BUS_SEQ -- requirements
Module: bus_seq

Interface
REQ-001 Parameter AW, default 16, address width in bits.
REQ-002 Parameter DW, default 8, data width in bits.
REQ-003 Parameter TCYC, default 4, T-states per M-cycle; legal range 3..8.
REQ-004 Parameter NCH, default 2, number of requester channels; legal range 1..4.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 req_valid  in  NCH  per-channel request pending.
REQ-008 req_ready  out  NCH  per-channel grant pulse.
REQ-009 req_op  in  2*NCH  per-channel op: 00 none, 01 fetch, 10 write, 11 read.
REQ-010 req_addr  in  AW*NCH  per-channel address.
REQ-011 req_wdata  in  DW*NCH  per-channel write data.
REQ-012 rsp_valid  out  1  response strobe.
REQ-013 rsp_ch  out  2  channel index of the response.
REQ-014 rsp_data  out  DW  captured read/fetch data.
REQ-015 a  out  AW  bus address.
REQ-016 dout  out  DW  bus write data.
REQ-017 din  in  DW  bus read data.
REQ-018 rd, wr, phi  out  1 each  bus strobes and phase clock.
REQ-019 wait_n  in  1  active-low wait request; extends the sample T-state.
REQ-020 mcycle_end  out  1  one-clock pulse in the last T-state.

Function
REQ-021 The T-state counter SHALL free-run 0..TCYC-1 and wrap to 0; T-states: T0 setup, T1..TCYC-3 access, TS = TCYC-2 sample, TL = TCYC-1 idle.
REQ-022 In T0 the block SHALL grant the lowest-index channel with req_valid=1 and req_op!=00; only that channel sees req_ready=1, for exactly one clock.
REQ-023 No eligible request in T0 SHALL produce an idle M-cycle: rd=wr=0, no rsp_valid, counter keeps running.
REQ-024 On the clock after grant the block SHALL present a = granted address, phi=1, and rd=1 for fetch/read.
REQ-025 In TS with wait_n=0 the counter SHALL hold at TS and all outputs SHALL hold; with wait_n=1 the sample actions SHALL occur.
REQ-026 Sample actions: write drives wr=1, dout = granted wdata; fetch/read capture din into rsp_data; in all cases rd=0 and phi=0.
REQ-027 For fetch/read, rsp_valid=1 SHALL pulse for one clock in TL with rsp_ch = granted index; for writes, rsp_valid stays 0.
REQ-028 In TL the block SHALL drive rd=0, wr=0, dout=0 and pulse mcycle_end=1.
REQ-029 Unbuffered latency, wait_n=1 throughout: grant at T0 to rsp_valid SHALL be TCYC-1 clocks.
REQ-030 Address and write data SHALL be registered at grant; requester changes after grant SHALL not affect the cycle.
REQ-031 Bits of rsp_ch above log2(NCH) SHALL be zero.

Reset
REQ-032 rst=0 SHALL immediately force a=0, dout=0, rd=0, wr=0, phi=0, req_ready=0, rsp_valid=0, rsp_ch=0, rsp_data=0, mcycle_end=0, counter=T0.
REQ-033 Reset mid-cycle SHALL abort the cycle with no response; the first grant opportunity is the first T0 after release.

Structure
REQ-034 A shared package SHALL hold the op encodings (none/fetch/write/read) and T-state role constants.
REQ-035 One sub-module, bus_arb, SHALL implement the fixed-priority NCH-way grant.

Verification
REQ-036 TCYC=4, ch0 read 0x1234, din=0xA5, wait_n=1 -> rd high for 2 clocks, rsp_valid at T3, rsp_data=0xA5, rsp_ch=0.
REQ-037 ch0 and ch1 both request in the same T0 -> ch0 granted; ch1 granted in the next M-cycle.
REQ-038 ch1 write 0xFF40 data 0x3C, wait_n=0 for 3 clocks at TS -> counter holds 3 clocks; wr=1 with dout=0x3C on release; no rsp_valid.
REQ-039 TCYC=6, NCH=4, ch3 fetch -> rsp_valid 5 clocks after grant, rsp_ch=3.
REQ-040 rst=0 pulse at T1 of a read -> outputs zero asynchronously, no rsp_valid; the next grant is at the first T0 after release.
REQ-041 No requests for 3 M-cycles -> mcycle_end every TCYC clocks; rd=wr=0 throughout.
